// File: rtl/motor_pkg.sv
// Shared motor-control constants and the per-channel RUN/DEAD encoding.
// The RPM reader and the PID top use the same package.
package motor_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_CHN     = 4;
    localparam int CHN_WIDTH   = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam int PWM_PERIOD  = 1000;
    localparam int WDT_PERIODS = 64;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chn_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One motor channel: abs/saturate, shadow and active duty, RUN/DEAD reversal FSM,
// stale-command watchdog and registered pwm/dir/timeout outputs.
module pwm_channel
    import motor_pkg::*;
#(
    parameter int  DW     = 16,
    parameter int  PERIOD = 1000,
    parameter int  WDT    = 64,
    localparam int CW     = $clog2(PERIOD + 1),
    localparam int WW     = $clog2(WDT + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_i,
    input  logic [DW-1:0] data_i,
    input  logic          boundary_i,
    input  logic [CW-1:0] cnt_i,
    output logic          pwm_o,
    output logic          dir_o,
    output logic          timeout_o
);

    logic          sdir_in;
    logic [DW:0]   mag_full;
    logic [CW-1:0] mag;

    logic [CW-1:0] sh_duty, act_duty, duty_nxt;
    logic          sh_dir, act_dir, dir_nxt;
    logic          tmo, pend;
    logic [WW-1:0] wdt, wdt_inc;
    chn_state_e    state, state_nxt;

    // One extra bit so that -2^(DW-1) has a representable magnitude.
    assign sdir_in  = data_i[DW-1];
    assign mag_full = sdir_in ? ({1'b0, ~data_i} + 1'b1) : {1'b0, data_i};
    assign mag      = (mag_full > (DW+1)'(PERIOD)) ? CW'(PERIOD) : mag_full[CW-1:0];

    assign wdt_inc  = (wdt == WW'(WDT)) ? wdt : wdt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= state_nxt;
    end

    // A stale channel holds its state; otherwise any reversal against a live
    // duty, or a second reversal while already dead, (re)starts the dead period.
    always_comb begin
        state_nxt = state;
        if (boundary_i && !(tmo && !pend)) begin
            if (sh_dir != act_dir)
                state_nxt = (state == DEAD || act_duty != '0) ? DEAD : RUN;
            else
                state_nxt = RUN;
        end
    end

    always_comb begin
        duty_nxt = act_duty;
        dir_nxt  = act_dir;
        if (boundary_i) begin
            if (tmo && !pend) begin
                duty_nxt = '0;
            end else begin
                dir_nxt  = sh_dir;
                duty_nxt = (state_nxt == DEAD) ? '0 : sh_duty;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_duty   <= '0;
            sh_dir    <= 1'b0;
            act_duty  <= '0;
            act_dir   <= 1'b0;
            tmo       <= 1'b0;
            pend      <= 1'b0;
            wdt       <= '0;
            pwm_o     <= 1'b0;
            dir_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if (wr_i) begin
                sh_duty <= mag;
                sh_dir  <= sdir_in;
            end
            act_duty <= duty_nxt;
            act_dir  <= dir_nxt;
            if (boundary_i)
                tmo <= pend ? 1'b0 : (wdt_inc == WW'(WDT));
            // A write on the boundary cycle counts toward the following period.
            if (wr_i) begin
                wdt  <= '0;
                pend <= 1'b1;
            end else if (boundary_i) begin
                wdt  <= pend ? '0 : wdt_inc;
                pend <= 1'b0;
            end
            // dir/timeout share the pwm register stage so all three switch together.
            pwm_o     <= (cnt_i < act_duty);
            dir_o     <= act_dir;
            timeout_o <= tmo;
        end
    end

endmodule

// File: rtl/motor_pwm_gen.sv
// Multi-channel H-bridge PWM generator fed by the time-multiplexed PID output stream.
// Shared period counter and tick here; per-channel work lives in pwm_channel.
module motor_pwm_gen #(
    parameter int  DATA_WIDTH  = motor_pkg::DATA_WIDTH,
    parameter int  NUM_CHN     = motor_pkg::NUM_CHN,
    parameter int  PWM_PERIOD  = motor_pkg::PWM_PERIOD,
    parameter int  WDT_PERIODS = motor_pkg::WDT_PERIODS,
    localparam int CHN_WIDTH   = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1,
    localparam int CNT_WIDTH   = $clog2(PWM_PERIOD + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  u_valid_i,
    input  logic [CHN_WIDTH-1:0]  u_chn_i,
    input  logic [DATA_WIDTH-1:0] u_data_i,
    output logic [NUM_CHN-1:0]    pwm_o,
    output logic [NUM_CHN-1:0]    dir_o,
    output logic [NUM_CHN-1:0]    timeout_o,
    output logic                  period_tick_o
);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 boundary;

    assign boundary = (cnt == CNT_WIDTH'(PWM_PERIOD - 1));

    // Tick is registered so it lines up with the pwm_o sample of cnt==0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt           <= '0;
            period_tick_o <= 1'b0;
        end else begin
            cnt           <= boundary ? '0 : cnt + 1'b1;
            period_tick_o <= (cnt == '0);
        end
    end

    // Channel indices past NUM_CHN match no instance and are dropped.
    for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
        pwm_channel #(
            .DW     (DATA_WIDTH),
            .PERIOD (PWM_PERIOD),
            .WDT    (WDT_PERIODS)
        ) u_chn (
            .clk        (clk),
            .rstn       (rstn),
            .wr_i       (u_valid_i && (u_chn_i == CHN_WIDTH'(i))),
            .data_i     (u_data_i),
            .boundary_i (boundary),
            .cnt_i      (cnt),
            .pwm_o      (pwm_o[i]),
            .dir_o      (dir_o[i]),
            .timeout_o  (timeout_o[i])
        );
    end

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Directed bench for motor_pwm_gen: a 4-channel and a 3-channel build on one command bus,
// per-period pulse measurement checked against a queue of expected channel states.
module tb_motor_pwm_gen;

    localparam int P   = 1000;
    localparam int WDT = 8;
    localparam int NL  = 7;  // lanes 0..3 = 4-channel build, 4..6 = 3-channel build

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        u_valid = 1'b0;
    logic [1:0]  u_chn = '0;
    logic [15:0] u_data = '0;
    logic [3:0]  pwm_a, dir_a, tmo_a;
    logic [2:0]  pwm_b, dir_b, tmo_b;
    logic        tick_a, tick_b;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string tag;
        int    lane;
        int    duty;
        bit    dir;
        bit    tmo;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    motor_pwm_gen #(.DATA_WIDTH(16), .NUM_CHN(4), .PWM_PERIOD(P), .WDT_PERIODS(WDT)) dut_a (
        .clk(clk), .rstn(rstn), .u_valid_i(u_valid), .u_chn_i(u_chn), .u_data_i(u_data),
        .pwm_o(pwm_a), .dir_o(dir_a), .timeout_o(tmo_a), .period_tick_o(tick_a));

    motor_pwm_gen #(.DATA_WIDTH(16), .NUM_CHN(3), .PWM_PERIOD(P), .WDT_PERIODS(WDT)) dut_b (
        .clk(clk), .rstn(rstn), .u_valid_i(u_valid), .u_chn_i(u_chn), .u_data_i(u_data),
        .pwm_o(pwm_b), .dir_o(dir_b), .timeout_o(tmo_b), .period_tick_o(tick_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input string tag, input int lane, input int duty,
                                     input bit dir, input bit tmo);
        exp_t e;
        e.tag = tag; e.lane = lane; e.duty = duty; e.dir = dir; e.tmo = tmo;
        sb.push_back(e);
    endfunction

    // Advance to the next negedge where the period tick is presented.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 2 * P);
        check("tick_wait", tick_a, 1);
        check("tick_same", tick_b, tick_a);
    endtask

    task automatic drive(input int ch, input int d);
        u_valid = 1'b1;
        u_chn   = 2'(ch);
        u_data  = 16'(d);
        @(negedge clk);
        u_valid = 1'b0;
    endtask

    // Wait for a period start, then write so the DUT captures it at cnt == c (c >= 1).
    task automatic write_at(input int ch, input int d, input int c);
        wait_tick();
        repeat (c - 1) @(negedge clk);
        drive(ch, d);
    endtask

    // Record one whole period on every lane, then pop and compare every queued expectation.
    task automatic measure();
        int         hi[NL];
        bit         shape[NL];
        logic       d0[NL];
        logic       t0[NL];
        logic [NL-1:0] p, d, t;
        exp_t       e;
        wait_tick();
        for (int k = 0; k < P; k++) begin
            if (k > 0) @(negedge clk);
            p = {pwm_b, pwm_a};
            d = {dir_b, dir_a};
            t = {tmo_b, tmo_a};
            for (int l = 0; l < NL; l++) begin
                if (k == 0) begin
                    hi[l] = 0; shape[l] = 1'b1; d0[l] = d[l]; t0[l] = t[l];
                end
                if (p[l] === 1'b1) begin
                    if (hi[l] != k) shape[l] = 1'b0;
                    hi[l]++;
                end else if (p[l] !== 1'b0) begin
                    shape[l] = 1'b0;
                end
                if (d[l] !== d0[l] || t[l] !== t0[l]) shape[l] = 1'b0;
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_duty"},  hi[e.lane], e.duty);
            check({e.tag, "_shape"}, shape[e.lane], 1);
            check({e.tag, "_dir"},   d0[e.lane], e.dir);
            check({e.tag, "_tmo"},   t0[e.lane], e.tmo);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pwm",  pwm_a, 0);
        check("rst_dir",  dir_a, 0);
        check("rst_tmo",  tmo_a, 0);
        check("rst_tick", tick_a, 0);
        rstn = 1'b1;

        // reset in the middle of a reverse 500 period
        write_at(0, -500, 10);
        wait_tick();
        repeat (100) @(negedge clk);
        check("t1_pwm_live", pwm_a[0], 1);
        check("t1_dir_live", dir_a[0], 1);
        #2 rstn = 1'b0;
        #1;
        check("t1_pwm_rst", pwm_a, 0);
        check("t1_dir_rst", dir_a, 0);
        check("t1_tmo_rst", tmo_a, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("t1_cnt_restart", tick_a, 1);

        // forward command mid-period; shadow of ch0 must be cleared by reset
        write_at(1, 250, 10);
        push_exp("t2_ch1", 1, 250, 1'b0, 1'b0);
        push_exp("t2_ch0", 0, 0, 1'b0, 1'b0);
        measure();

        // reversal with live duty: one dead period then the new duty
        write_at(2, 400, 10);
        push_exp("t3_fwd", 2, 400, 1'b0, 1'b0);
        measure();
        write_at(2, -300, 10);
        push_exp("t3_dead", 2, 0, 1'b1, 1'b0);
        measure();
        push_exp("t3_rev", 2, 300, 1'b1, 1'b0);
        push_exp("t3_rev_b", 6, 300, 1'b1, 1'b0);
        measure();

        // saturation both ways
        write_at(1, 5000, 10);
        drive(2, 'h8000);
        push_exp("t4_pos", 1, P, 1'b0, 1'b0);
        push_exp("t4_neg", 2, P, 1'b1, 1'b0);
        measure();

        // watchdog expiry and recovery
        write_at(0, 600, 10);
        push_exp("t5_start", 0, 600, 1'b0, 1'b0);
        measure();
        repeat (6) wait_tick();
        push_exp("t5_last_ok", 0, 600, 1'b0, 1'b0);
        measure();
        push_exp("t5_expire", 0, 600, 1'b0, 1'b1);
        measure();
        push_exp("t5_zeroed", 0, 0, 1'b0, 1'b1);
        push_exp("t5_zeroed_b", 4, 0, 1'b0, 1'b1);
        measure();
        write_at(0, 100, 10);
        push_exp("t5_recover", 0, 100, 1'b0, 1'b0);
        push_exp("t5_recover_b", 4, 100, 1'b0, 1'b0);
        measure();

        // last write wins; boundary-cycle write lands one period late; chn 3 absent in 3-chn build
        write_at(0, 200, 10);
        drive(0, 700);
        repeat (P - 1 - 12) @(negedge clk);
        drive(3, -450);
        push_exp("t6_ch0_last", 0, 700, 1'b0, 1'b0);
        push_exp("t6_ch3_late", 3, 0, 1'b0, 1'b1);
        push_exp("t6_ch1_stale", 1, 0, 1'b0, 1'b1);
        push_exp("t6_ch2_stale", 2, 0, 1'b1, 1'b1);
        push_exp("t6_b_ch0", 4, 700, 1'b0, 1'b0);
        push_exp("t6_b_ch1", 5, 0, 1'b0, 1'b1);
        push_exp("t6_b_ch2", 6, 0, 1'b1, 1'b1);
        measure();
        push_exp("t6_ch3_apply", 3, 450, 1'b1, 1'b0);
        push_exp("t6_ch0_hold", 0, 700, 1'b0, 1'b0);
        push_exp("t6_b_ch0_hold", 4, 700, 1'b0, 1'b0);
        push_exp("t6_b_ch1_hold", 5, 0, 1'b0, 1'b1);
        push_exp("t6_b_ch2_hold", 6, 0, 1'b1, 1'b1);
        measure();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
